// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared memory package: access sizes and requester indices
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_R = 2'b11
    } size_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_idx_e;

endpackage

// File: rtl/dmem_align_chk.sv
// rtl/dmem_align_chk.sv - flags misaligned or reserved-size data memory accesses
module dmem_align_chk
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [1:0] size,
    output logic       misaligned
);

    // halfwords need even addresses, words need 4-byte alignment, size 11 is never legal
    always_comb begin
        misaligned = 1'b0;
        if (size == SZ_H && addr_lo[0])
            misaligned = 1'b1;
        if (size == SZ_W && addr_lo != 2'b00)
            misaligned = 1'b1;
        if (size == SZ_R)
            misaligned = 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin core/debug arbiter for a single-port data memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    input  logic [1:0]    c_size,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic          c_err,
    output logic [DW-1:0] c_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [1:0]    d_size,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic [1:0]    mem_be,
    input  logic [DW-1:0] mem_rd
);

    req_idx_e last_q;

    logic     rsp_valid_q;
    req_idx_e rsp_owner_q;
    logic     rsp_err_q;
    logic     rsp_read_q;

    logic     c_mis;
    logic     d_mis;
    logic [DW-1:0] rsp_data;

    dmem_align_chk u_c_align (
        .addr_lo    (c_addr[1:0]),
        .size       (c_size),
        .misaligned (c_mis)
    );

    dmem_align_chk u_d_align (
        .addr_lo    (d_addr[1:0]),
        .size       (d_size),
        .misaligned (d_mis)
    );

    // grant the sole requester, or under contention the one that did not win last
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            c_gnt = c_req && (!d_req || last_q == REQ_DBG);
            d_gnt = d_req && (!c_req || last_q == REQ_CORE);
        end
    end

    // steer the winner onto the memory port; misaligned accesses never write
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        mem_be = 2'b00;
        if (c_gnt) begin
            mem_we = c_we && !c_mis;
            mem_a  = c_addr;
            mem_wd = c_wdata;
            mem_be = c_size;
        end else if (d_gnt) begin
            mem_we = d_we && !d_mis;
            mem_a  = d_addr;
            mem_wd = d_wdata;
            mem_be = d_size;
        end
    end

    // round-robin pointer and one-deep response tracker for the cycle-N winner
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q      <= REQ_DBG;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= REQ_CORE;
            rsp_err_q   <= 1'b0;
            rsp_read_q  <= 1'b0;
        end else begin
            rsp_valid_q <= c_gnt || d_gnt;
            if (c_gnt) begin
                last_q      <= REQ_CORE;
                rsp_owner_q <= REQ_CORE;
                rsp_err_q   <= c_mis;
                rsp_read_q  <= !c_we;
            end else if (d_gnt) begin
                last_q      <= REQ_DBG;
                rsp_owner_q <= REQ_DBG;
                rsp_err_q   <= d_mis;
                rsp_read_q  <= !d_we;
            end
        end
    end

    // route the response to its owner; writes and errors return zero data
    always_comb begin
        rsp_data = (rsp_valid_q && !rsp_err_q && rsp_read_q) ? mem_rd : '0;
        c_rvalid = rsp_valid_q && rsp_owner_q == REQ_CORE;
        d_rvalid = rsp_valid_q && rsp_owner_q == REQ_DBG;
        c_err    = c_rvalid && rsp_err_q;
        d_err    = d_rvalid && rsp_err_q;
        c_rdata  = c_rvalid ? rsp_data : '0;
        d_rdata  = d_rvalid ? rsp_data : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    typedef logic [31:0] w_t;

    typedef struct {
        w_t rs;
        w_t cr, cw, ca, cwd, cs;
        w_t dr, dw, da, dwd, ds;
        w_t mrd;
        w_t ecg, edg, emwe, ema, emwd, embe;
        w_t ecv, ece, ecd;
        w_t edv, ede, edd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, c_gnt, c_rvalid, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [1:0]  c_size;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [1:0]  mem_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_size   (c_size),
        .c_gnt    (c_gnt),
        .c_rvalid (c_rvalid),
        .c_err    (c_err),
        .c_rdata  (c_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_size   (d_size),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_err    (d_err),
        .d_rdata  (d_rdata),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_be   (mem_be),
        .mem_rd   (mem_rd)
    );

    task automatic chk(input string name, input int row, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset   = v.rs[0];
        c_req   = v.cr[0];
        c_we    = v.cw[0];
        c_addr  = v.ca;
        c_wdata = v.cwd;
        c_size  = v.cs[1:0];
        d_req   = v.dr[0];
        d_we    = v.dw[0];
        d_addr  = v.da;
        d_wdata = v.dwd;
        d_size  = v.ds[1:0];
        mem_rd  = v.mrd;
    endtask

    vec_t tbl[26];

    initial begin
        //        rs  cr cw ca     cwd      cs  dr dw da     dwd          ds  mrd            ecg edg mwe ema    emwd         mbe ecv ece ecd            edv ede edd
        tbl[0]  = '{0, 1, 0, 'h100, 0,       2,  1, 0, 'h200, 0,           2,  0,             0,  0,  0,  0,     0,           0,  0,  0,  0,             0,  0,  0};
        tbl[1]  = '{1, 1, 0, 'h100, 0,       2,  1, 0, 'h200, 0,           2,  0,             1,  0,  0,  'h100, 0,           2,  0,  0,  0,             0,  0,  0};
        tbl[2]  = '{1, 1, 0, 'h100, 0,       2,  1, 0, 'h200, 0,           2,  'h11111111,    0,  1,  0,  'h200, 0,           2,  1,  0,  'h11111111,    0,  0,  0};
        tbl[3]  = '{1, 1, 0, 'h100, 0,       2,  1, 0, 'h200, 0,           2,  'h22222222,    1,  0,  0,  'h100, 0,           2,  0,  0,  0,             1,  0,  'h22222222};
        tbl[4]  = '{1, 1, 0, 'h100, 0,       2,  1, 0, 'h200, 0,           2,  'h33333333,    0,  1,  0,  'h200, 0,           2,  1,  0,  'h33333333,    0,  0,  0};
        tbl[5]  = '{1, 0, 0, 0,     0,       0,  0, 0, 0,     0,           0,  'h44444444,    0,  0,  0,  0,     0,           0,  0,  0,  0,             1,  0,  'h44444444};
        tbl[6]  = '{1, 1, 0, 'h40,  0,       2,  0, 0, 0,     0,           0,  'h55555555,    1,  0,  0,  'h40,  0,           2,  0,  0,  0,             0,  0,  0};
        tbl[7]  = '{1, 0, 0, 0,     0,       0,  0, 0, 0,     0,           0,  'hDEADBEEF,    0,  0,  0,  0,     0,           0,  1,  0,  'hDEADBEEF,    0,  0,  0};
        tbl[8]  = '{1, 0, 0, 0,     0,       0,  1, 1, 'h10,  'h12345678,  2,  0,             0,  1,  1,  'h10,  'h12345678,  2,  0,  0,  0,             0,  0,  0};
        tbl[9]  = '{1, 0, 0, 0,     0,       0,  0, 0, 0,     0,           0,  'hAAAAAAAA,    0,  0,  0,  0,     0,           0,  0,  0,  0,             1,  0,  0};
        tbl[10] = '{1, 1, 1, 'h41,  'hCAFE,  1,  0, 0, 0,     0,           0,  0,             1,  0,  0,  'h41,  'hCAFE,      1,  0,  0,  0,             0,  0,  0};
        tbl[11] = '{1, 0, 0, 0,     0,       0,  0, 0, 0,     0,           0,  'hBBBBBBBB,    0,  0,  0,  0,     0,           0,  1,  1,  0,             0,  0,  0};
        tbl[12] = '{1, 1, 0, 'h0,   0,       2,  0, 0, 0,     0,           0,  0,             1,  0,  0,  'h0,   0,           2,  0,  0,  0,             0,  0,  0};
        tbl[13] = '{1, 1, 0, 'h4,   0,       2,  0, 0, 0,     0,           0,  'h1000,        1,  0,  0,  'h4,   0,           2,  1,  0,  'h1000,        0,  0,  0};
        tbl[14] = '{1, 1, 0, 'h8,   0,       2,  0, 0, 0,     0,           0,  'h1004,        1,  0,  0,  'h8,   0,           2,  1,  0,  'h1004,        0,  0,  0};
        tbl[15] = '{1, 0, 0, 0,     0,       0,  0, 0, 0,     0,           0,  'h1008,        0,  0,  0,  0,     0,           0,  1,  0,  'h1008,        0,  0,  0};
        tbl[16] = '{1, 0, 0, 0,     0,       0,  1, 0, 'h20,  0,           3,  0,             0,  1,  0,  'h20,  0,           3,  0,  0,  0,             0,  0,  0};
        tbl[17] = '{1, 0, 0, 0,     0,       0,  0, 0, 0,     0,           0,  'hCCCCCCCC,    0,  0,  0,  0,     0,           0,  0,  0,  0,             1,  1,  0};
        tbl[18] = '{1, 1, 0, 'h22,  0,       2,  0, 0, 0,     0,           0,  0,             1,  0,  0,  'h22,  0,           2,  0,  0,  0,             0,  0,  0};
        tbl[19] = '{1, 0, 0, 0,     0,       0,  1, 1, 'h22,  'hBEEF,      1,  'hDDDDDDDD,    0,  1,  1,  'h22,  'hBEEF,      1,  1,  1,  0,             0,  0,  0};
        tbl[20] = '{1, 0, 0, 0,     0,       0,  0, 0, 0,     0,           0,  'hEEEEEEEE,    0,  0,  0,  0,     0,           0,  0,  0,  0,             1,  0,  0};
        tbl[21] = '{1, 1, 0, 'h30,  0,       2,  0, 0, 0,     0,           0,  0,             1,  0,  0,  'h30,  0,           2,  0,  0,  0,             0,  0,  0};
        tbl[22] = '{1, 0, 0, 0,     0,       0,  0, 0, 0,     0,           0,  'h77,          0,  0,  0,  0,     0,           0,  1,  0,  'h77,          0,  0,  0};
        tbl[23] = '{0, 1, 0, 'h40,  0,       2,  1, 0, 'h200, 0,           2,  'h88,          0,  0,  0,  0,     0,           0,  0,  0,  0,             0,  0,  0};
        tbl[24] = '{1, 1, 0, 'h40,  0,       2,  1, 0, 'h200, 0,           2,  'h99,          1,  0,  0,  'h40,  0,           2,  0,  0,  0,             0,  0,  0};
        tbl[25] = '{1, 0, 0, 0,     0,       0,  0, 0, 0,     0,           0,  'h66,          0,  0,  0,  0,     0,           0,  1,  0,  'h66,          0,  0,  0};

        drive(tbl[0]);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #2;
            chk("c_gnt",    i, 32'(c_gnt),    tbl[i].ecg);
            chk("d_gnt",    i, 32'(d_gnt),    tbl[i].edg);
            chk("mem_we",   i, 32'(mem_we),   tbl[i].emwe);
            chk("mem_a",    i, mem_a,         tbl[i].ema);
            chk("mem_wd",   i, mem_wd,        tbl[i].emwd);
            chk("mem_be",   i, 32'(mem_be),   tbl[i].embe);
            chk("c_rvalid", i, 32'(c_rvalid), tbl[i].ecv);
            chk("c_err",    i, 32'(c_err),    tbl[i].ece);
            chk("c_rdata",  i, c_rdata,       tbl[i].ecd);
            chk("d_rvalid", i, 32'(d_rvalid), tbl[i].edv);
            chk("d_err",    i, 32'(d_err),    tbl[i].ede);
            chk("d_rdata",  i, d_rdata,       tbl[i].edd);
        end

        // sustained contention: core won last (row 24), so debug leads and they alternate
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            reset   = 1'b1;
            c_req   = (k < 6);
            c_we    = 1'b0;
            c_addr  = 32'h100;
            c_size  = 2'b10;
            d_req   = (k < 6);
            d_we    = 1'b0;
            d_addr  = 32'h200;
            d_size  = 2'b10;
            mem_rd  = 32'hA000 + k;
            #2;
            if (k < 6) begin
                chk("alt_c_gnt", 100 + k, 32'(c_gnt), 32'(k % 2));
                chk("alt_d_gnt", 100 + k, 32'(d_gnt), 32'((k + 1) % 2));
            end
            if (k > 0) begin
                chk("alt_c_rvalid", 100 + k, 32'(c_rvalid), 32'((k - 1) % 2));
                chk("alt_d_rvalid", 100 + k, 32'(d_rvalid), 32'(k % 2));
                chk("alt_rdata", 100 + k, c_rdata | d_rdata, 32'hA000 + k);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
